// File: rtl/logic_op_arbiter_pkg.sv
// logic_op_arbiter_pkg: op encodings, operand width, state encoding and the shared logic unit.
// Revision 1.0
`default_nettype none

package logic_op_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } result_t;

  // Illegal selects yield zero with the error flag set.
  function automatic result_t logic_unit(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [2:0]        sel);
    result_t r;
    r.err  = 1'b0;
    r.data = '0;
    case (sel)
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_XOR:  r.data = a ^ b;
      OP_NOT:  r.data = ~a;
      default: r.err  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_op_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; prio decides only when both requesters are valid.
// Revision 1.0
`default_nettype none

module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant
);

  assign grant = (valid0 && valid1) ? prio : valid1;

endmodule

`default_nettype wire

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: two requesters share one logic unit, registered response channel.
// Optional grant counters under LOGIC_OP_ARBITER_STATS_EN. Revision 1.0
`default_nettype none

module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_err
`ifdef LOGIC_OP_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  state_t            state;
  logic              prio;
  logic              grant;
  logic              can_accept;
  logic              acc0;
  logic              acc1;
  logic              accept;
  logic [DATA_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_b;
  logic [2:0]        mux_sel;
  result_t           result;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .prio   (prio),
    .grant  (grant)
  );

  assign can_accept = (state == IDLE) || rsp_ready;
  assign req0_ready = can_accept && !grant;
  assign req1_ready = can_accept && grant;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;

  assign mux_a   = grant ? req1_a   : req0_a;
  assign mux_b   = grant ? req1_b   : req0_b;
  assign mux_sel = grant ? req1_sel : req0_sel;
  assign result  = logic_unit(mux_a, mux_b, mux_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      prio      <= INIT_PRIO;
    end else if (accept) begin
      state     <= HOLD;
      rsp_valid <= 1'b1;
      rsp_data  <= result.data;
      rsp_id    <= grant;
      rsp_err   <= result.err;
      prio      <= ~grant;
    end else if (rsp_ready) begin
      // Drained with nothing new: payload registers keep their last value.
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

`ifdef LOGIC_OP_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (acc0 && (grant_cnt0 != {CNT_W{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (acc1 && (grant_cnt1 != {CNT_W{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`else
  // CNT_W only sizes the grant counters, which are absent in this build.
  if (CNT_W < 1) begin : g_no_stats
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed stimulus, queue-based response model checked every cycle.
// Revision 1.0
`default_nettype none

module tb_logic_op_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_sel = '0, req1_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;
`ifdef LOGIC_OP_ARBITER_STATS_EN
  logic [1:0]  grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.CNT_W(2), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
`ifdef LOGIC_OP_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] data;
    logic        id;
    logic        err;
  } rsp_t;

  rsp_t q[$];
  rsp_t m_last;
  logic m_prio;
  int   m_cnt0, m_cnt1;

  function automatic rsp_t compute(input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] sel, input logic id);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (sel)
      3'd0:    r.data = a & b;
      3'd1:    r.data = a | b;
      3'd2:    r.data = a ^ b;
      3'd4:    r.data = ~a;
      default: begin r.data = 16'h0000; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  // Which requester the rules pick (-1 if no one may go this cycle).
  function automatic int winner();
    bit room;
    room = (q.size() == 0) || rsp_ready;
    if (!room) return -1;
    if (req0_valid && req1_valid) return int'(m_prio);
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = '{data: 16'h0, id: 1'b0, err: 1'b0};
      m_prio = 1'b0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      int w;
      w = winner();
      if (q.size() != 0 && rsp_ready) void'(q.pop_front());
      if (w == 0) begin
        m_last = compute(req0_a, req0_b, req0_sel, 1'b0);
        q.push_back(m_last);
        m_prio = 1'b1;
        if (m_cnt0 < 3) m_cnt0++;
      end else if (w == 1) begin
        m_last = compute(req1_a, req1_b, req1_sel, 1'b1);
        q.push_back(m_last);
        m_prio = 1'b0;
        if (m_cnt1 < 3) m_cnt1++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid || req1_valid) begin
        int w;
        w = winner();
        chk("model_ready0", req0_ready, w == 0);
        chk("model_ready1", req1_ready, w == 1);
      end
      chk("model_rsp_valid", rsp_valid, q.size() != 0);
      chk("model_rsp_data", rsp_data, m_last.data);
      chk("model_rsp_id", rsp_id, m_last.id);
      chk("model_rsp_err", rsp_err, m_last.err);
`ifdef LOGIC_OP_ARBITER_STATS_EN
      chk("model_cnt0", grant_cnt0, m_cnt0);
      chk("model_cnt1", grant_cnt1, m_cnt1);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    step();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_data", rsp_data, 16'h0);
    chk("reset_id", rsp_id, 1'b0);
    chk("reset_err", rsp_err, 1'b0);
    step();
    rst_n = 1'b1;

    // Single request from requester 0
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_sel = 3'b000;
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_data", rsp_data, 16'hF000);
    chk("t1_id", rsp_id, 1'b0);
    chk("t1_err", rsp_err, 1'b0);

    // Round-robin under constant contention
    pulse_reset();
    rsp_ready = 1'b1;
    req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_sel = 3'b001;
    req1_a = 16'hF0F0; req1_b = 16'hFF00; req1_sel = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_ready0", req0_ready, (k % 2) == 0);
      chk("rr_ready1", req1_ready, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_valid", rsp_valid, 1'b1);
        chk("rr_data", rsp_data, (k % 2 == 1) ? 16'hFFF0 : 16'h0FF0);
        chk("rr_id", rsp_id, (k % 2 == 1) ? 1'b0 : 1'b1);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("rr_last_data", rsp_data, 16'h0FF0);
    chk("rr_last_id", rsp_id, 1'b1);

    // Backpressure hold, then release with requester 1 waiting
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_sel = 3'b000;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h0000; req1_sel = 3'b100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ready0", req0_ready, 1'b0);
      chk("hold_ready1", req1_ready, 1'b0);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, 16'hF000);
      chk("hold_id", rsp_id, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_ready1", req1_ready, 1'b1);
    step();
    req1_sel = 3'b111;
    @(negedge clk);
    chk("not_valid", rsp_valid, 1'b1);
    chk("not_data", rsp_data, 16'hEDCB);
    chk("not_id", rsp_id, 1'b1);
    chk("not_err", rsp_err, 1'b0);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("illegal_data", rsp_data, 16'h0000);
    chk("illegal_err", rsp_err, 1'b1);

    // Asynchronous reset while holding a response
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_sel = 3'b010;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", rsp_valid, 1'b1);
    chk("pre_rst_data", rsp_data, 16'h0FF0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_data", rsp_data, 16'h0000);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", rsp_valid, 1'b0);
    step();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_sel = 3'b000; req1_sel = 3'b000;
    @(negedge clk);
    chk("post_rst_prio0", req0_ready, 1'b1);
    chk("post_rst_prio1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_id", rsp_id, 1'b0);

`ifdef LOGIC_OP_ARBITER_STATS_EN
    // Counter saturation with a 2-bit width
    pulse_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("sat_cnt0", grant_cnt0, 2'd3);
    chk("sat_cnt1", grant_cnt1, 2'd0);
`endif

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one 16-bit logic unit (AND/OR/XOR/NOT, 3-bit op select) between two requesters.
- Each requester issues {a, b, sel} with a valid/ready handshake. A round-robin arbiter grants one request per cycle.
- The result is registered and returned on a single valid/ready response channel, tagged with the requester id and an illegal-op flag.
- Sits between the instruction-issue logic and the logic datapath, replacing direct per-client instantiation of the logic unit.

Parameters:
- CNT_W, 16: width of the grant counters (used only with the optional feature).
- INIT_PRIO, 0: requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  16  operand A.
- req0_b  in  16  operand B.
- req0_sel  in  3  op select.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  16  result.
- rsp_id  out  1  requester the result belongs to.
- rsp_err  out  1  op select was illegal.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, prio=INIT_PRIO, counters=0. Any pending response is dropped, with no partial output.
- Op encoding:
  - 000 = A&B
  - 001 = A|B
  - 010 = A^B
  - 100 = ~A
  - 011/101/110/111 are illegal: result 16'h0000, rsp_err=1. No simulation messages.
- States: IDLE (no held response), HOLD (rsp_valid=1, response registers stable).
- can_accept = (state==IDLE) || rsp_ready.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester equal to prio wins.
  - reqN_ready = can_accept && grant==N. At most one ready is high per cycle.
  - ready never depends on the same requester's valid in a way that forms a loop. It is a function of can_accept, both valids and prio.
- Accept (reqN_valid && reqN_ready at the edge):
  - Compute the result from requester N's a/b/sel.
  - Register rsp_data, rsp_id=N, rsp_err.
  - rsp_valid=1 on the next cycle; state=HOLD.
  - prio=~N (the loser of the next contention is the requester just served).
- Latency: 1 cycle from accept to rsp_valid. Throughput is 1 op/cycle while rsp_ready stays high.
- HOLD:
  - rsp_data, rsp_id and rsp_err stay stable until rsp_ready.
  - On rsp_ready with no new accept: rsp_valid=0, state=IDLE, data registers keep their last value.
  - On rsp_ready with a simultaneous accept: registers load the new result, rsp_valid stays 1.
- No valid requests: prio is unchanged, no state change.
- A requester may drop valid without being accepted. No requirement is placed on requesters beyond standard valid/ready (operands are sampled only on the accept edge).

Optional Feature:
- Macro LOGIC_OP_ARBITER_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 [CNT_W-1:0].
  - Each counter increments on an accept for its requester and saturates at all-ones (no wrap).
  - Both counters reset to 0.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - Op-select constants (OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NOT=3'b100).
  - The operand width constant (16).
  - The state encoding (IDLE, HOLD).
- Natural sub-module: rr_arb2, a 2-input round-robin grant with prio input and grant output, purely combinational.
- Result computation is the existing shared logic unit, instantiated once on the muxed operands. Illegal ops are mapped to 0 with err by this block.

Test Plan:
- Reset, then req0 only: a=16'hF0F0, b=16'hFF00, sel=000. Expect req0_ready=1; next cycle rsp_valid=1, rsp_data=16'hF000, rsp_id=0, rsp_err=0.
- Both valid every cycle, rsp_ready=1, INIT_PRIO=0: accept order is 0,1,0,1. Responses follow back-to-back with no bubble. sel=001 gives 16'hFFF0; sel=010 gives 16'h0FF0.
- rsp_ready=0 for 5 cycles after a response: rsp_data/rsp_id stay stable and both readys stay low. Raise rsp_ready with req1 valid: req1 is accepted that cycle and the new response appears the next cycle.
- sel=100, a=16'h1234: expect 16'hEDCB, err=0. Then sel=111: expect rsp_data=16'h0000, rsp_err=1.
- Assert rst_n low while in HOLD: rsp_valid drops immediately (async). After release, prio=INIT_PRIO and no stale response appears.
- With LOGIC_OP_ARBITER_STATS_EN and CNT_W=2: accept 5 ops from req0. grant_cnt0 reads 3 (saturated), grant_cnt1 reads 0.
